// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   WIDTH_DEF : default operand/result width
//   CNT_W     : bit-position counter width
//   state_t   : controller states
package sub_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: computes x - y - bin.
//   x, y  : operand bits
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    // Borrow when y > x outright, or when x == y and a borrow is pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor d = a - b, LSB first, one bit per clock, using a
// single full-subtractor cell. start is sampled in IDLE only; results and
// flags update together with a one-cycle done pulse and then hold.
//   clk, rst_n : clock, async active-low reset
//   start      : launch request (ignored while busy)
//   a, b       : minuend / subtrahend, captured on the start edge
//   d          : difference mod 2^WIDTH
//   bout       : unsigned borrow (a < b)
//   ovf        : two's-complement overflow
//   zero       : d == 0
//   busy       : operation in progress
//   done       : one-cycle pulse when outputs update
module serial_subtractor_8bit
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic             fs_diff;
    logic             fs_bout;

    full_subtractor_1bit u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Operands rotate rather than shift so that after WIDTH
                    // steps they are back in place and the sign bits are
                    // available for the overflow flag in DONE.
                    a_sr   <= {a_sr[0], a_sr[WIDTH-1:1]};
                    b_sr   <= {b_sr[0], b_sr[WIDTH-1:1]};
                    res_sr <= {fs_diff, res_sr[WIDTH-1:1]};
                    br     <= fs_bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    d     <= res_sr;
                    bout  <= br;
                    ovf   <= (a_sr[WIDTH-1] ^ b_sr[WIDTH-1]) &
                             (res_sr[WIDTH-1] ^ a_sr[WIDTH-1]);
                    zero  <= (res_sr == '0);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
module tb_serial_subtractor_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] ain;
    logic [7:0] bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    logic       zero;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    serial_subtractor_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (ain),
        .b     (bin),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operand values.
    function automatic logic [7:0] m_d(input logic [7:0] x, input logic [7:0] y);
        int r;
        r = int'(x) - int'(y);
        return 8'(r & 255);
    endfunction
    function automatic logic m_bout(input logic [7:0] x, input logic [7:0] y);
        return int'(x) < int'(y);
    endfunction
    function automatic logic m_ovf(input logic [7:0] x, input logic [7:0] y);
        int sx, sy, r;
        sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
        r  = sx - sy;
        return (r > 127) || (r < -128);
    endfunction

    // Launch one operation and wait for done. lat = edges after the start edge.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          output int lat, output logic busy0,
                          output logic [7:0] od, output logic ob,
                          output logic oo, output logic oz,
                          output logic done_next);
        @(negedge clk);
        ain = x; bin = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy0 = busy;
        ain = 8'($urandom); bin = 8'($urandom);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        od = d; ob = bout; oo = ovf; oz = zero;
        @(posedge clk);
        #1;
        done_next = done;
    endtask

    task automatic do_and_check(input string nm, input logic [7:0] x, input logic [7:0] y);
        int lat;
        logic b0, ob, oo, oz, dn;
        logic [7:0] od;
        run_op(x, y, lat, b0, od, ob, oo, oz, dn);
        checks += 7;
        if (lat !== 9) begin failures++; $display("FAIL %s latency got=%0d exp=9", nm, lat); end
        if (b0 !== 1'b1) begin failures++; $display("FAIL %s busy got=%b exp=1", nm, b0); end
        if (od !== m_d(x, y)) begin failures++; $display("FAIL %s d got=%h exp=%h (a=%h b=%h)", nm, od, m_d(x, y), x, y); end
        if (ob !== m_bout(x, y)) begin failures++; $display("FAIL %s bout got=%b exp=%b (a=%h b=%h)", nm, ob, m_bout(x, y), x, y); end
        if (oo !== m_ovf(x, y)) begin failures++; $display("FAIL %s ovf got=%b exp=%b (a=%h b=%h)", nm, oo, m_ovf(x, y), x, y); end
        if (oz !== (m_d(x, y) == 8'h00)) begin failures++; $display("FAIL %s zero got=%b exp=%b", nm, oz, m_d(x, y) == 8'h00); end
        if (dn !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", nm, dn); end
    endtask

    task automatic test_reset();
        checks += 6;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_d got=%h exp=00", d); end
        if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout); end
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_vectors();
        do_and_check("v_1e_01", 8'h1E, 8'h01);
        do_and_check("v_23_04", 8'h23, 8'h04);
        do_and_check("v_00_01", 8'h00, 8'h01);
        do_and_check("v_80_01", 8'h80, 8'h01);
        do_and_check("v_55_55", 8'h55, 8'h55);
        do_and_check("v_7f_ff", 8'h7F, 8'hFF);
        do_and_check("v_ff_00", 8'hFF, 8'h00);
        do_and_check("v_00_80", 8'h00, 8'h80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            do_and_check("rand", 8'($urandom), 8'($urandom));
    endtask

    task automatic test_ignore_start();
        int         npulse;
        logic [7:0] got;
        npulse = 0;
        got    = 8'hxx;
        @(negedge clk);
        ain = 8'h9C; bin = 8'h3A; start = 1'b1;
        @(posedge clk);                       // edge 0
        #1 start = 1'b0;
        @(posedge clk);                       // edge 1
        @(posedge clk);                       // edge 2
        @(negedge clk);
        ain = 8'h01; bin = 8'h02; start = 1'b1;
        @(posedge clk);                       // edge 3, while busy
        #1 start = 1'b0;
        for (int k = 4; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                npulse++;
                got = d;
            end
        end
        checks += 2;
        if (npulse !== 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", npulse); end
        if (got !== m_d(8'h9C, 8'h3A)) begin failures++; $display("FAIL ignore_d got=%h exp=%h", got, m_d(8'h9C, 8'h3A)); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        do_and_check("pre_reset", 8'hF0, 8'h0F);   // leave non-reset values on outputs
        @(negedge clk);
        ain = 8'h44; bin = 8'h11; start = 1'b1;
        @(posedge clk);                       // edge 0
        #1 start = 1'b0;
        for (int k = 1; k <= 4; k++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 6;
        if (d !== 8'h00) begin failures++; $display("FAIL midrst_d got=%h exp=00", d); end
        if (bout !== 1'b0) begin failures++; $display("FAIL midrst_bout got=%b exp=0", bout); end
        if (ovf !== 1'b0) begin failures++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
        if (zero !== 1'b1) begin failures++; $display("FAIL midrst_zero got=%b exp=1", zero); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks += 1;
        if (ndone !== 0) begin failures++; $display("FAIL midrst_nodone got=%0d exp=0", ndone); end
        do_and_check("post_reset", 8'h3C, 8'h5A);
    endtask

    task automatic test_back_to_back();
        int q[$];
        int exp_edges[3] = '{9, 19, 29};
        @(negedge clk);
        ain = 8'h10; bin = 8'h20; start = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k == 29) start = 1'b0;
            if (done) begin
                q.push_back(k);
                checks += 2;
                if (d !== m_d(8'h10, 8'h20)) begin failures++; $display("FAIL b2b_d edge=%0d got=%h exp=%h", k, d, m_d(8'h10, 8'h20)); end
                if (bout !== 1'b1) begin failures++; $display("FAIL b2b_bout edge=%0d got=%b exp=1", k, bout); end
            end
        end
        checks += 1;
        if (q.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 1;
                if (q[i] !== exp_edges[i]) begin failures++; $display("FAIL b2b_edge%0d got=%0d exp=%0d", i, q[i], exp_edges[i]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ain   = 8'h00;
        bin   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_vectors();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
